// File: rtl/pmod_adc_pkg.sv
// rtl/pmod_adc_pkg.sv - state codes, frame constants and counter sizing for pmod_adc_reader
package pmod_adc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_QUIET = 3'd4;

  localparam int DEF_FRAME_BITS = 16;
  localparam int DEF_DATA_WIDTH = 12;
  localparam int LEAD_BITS      = DEF_FRAME_BITS - DEF_DATA_WIDTH;
  localparam int MIN_CLK_DIV    = 4;

  // Bits needed to hold any value 0..max_val.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((2 ** w) <= max_val) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/pmod_adc_sync.sv
// rtl/pmod_adc_sync.sv - two-flop synchroniser for one asynchronous ADC data line
module pmod_adc_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pmod_adc_reader.sv
// rtl/pmod_adc_reader.sv - dual-channel serial ADC reader (PMOD AD1), single-shot or continuous
// PMOD_ADC_FRAME_CHECK_EN adds frame_err, flagging nonzero discarded leading bits.
module pmod_adc_reader
  import pmod_adc_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int FRAME_BITS   = DEF_FRAME_BITS,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int QUIET_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  input  logic                  adc_sdata0,
`ifdef PMOD_ADC_FRAME_CHECK_EN
  input  logic                  adc_sdata1,
  output logic                  frame_err
`else
  input  logic                  adc_sdata1
`endif
);

  localparam int DIV     = (CLK_DIV < MIN_CLK_DIV) ? MIN_CLK_DIV : CLK_DIV;
  localparam int CNT_MAX = (DIV > QUIET_CYCLES - 1) ? DIV : QUIET_CYCLES - 1;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam int BIT_W   = cnt_width(FRAME_BITS - 1);

  // SETUP spans the chip-select entry cycle plus DIV setup cycles, hence 0..DIV.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

`ifdef PMOD_ADC_FRAME_CHECK_EN
  localparam int SHIFT_W = FRAME_BITS;
  logic frame_err_q, frame_err_d;
`else
  // Leading bits simply fall off the top of a DATA_WIDTH register.
  localparam int SHIFT_W = DATA_WIDTH;
`endif

  logic sdata0_sync;
  logic sdata1_sync;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [SHIFT_W-1:0]    shift0_q, shift0_d;
  logic [SHIFT_W-1:0]    shift1_q, shift1_d;
  logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
  logic [DATA_WIDTH-1:0] dout1_q, dout1_d;

  pmod_adc_sync u_sync0 (.clk(clk), .rst(rst), .d(adc_sdata0), .q(sdata0_sync));
  pmod_adc_sync u_sync1 (.clk(clk), .rst(rst), .d(adc_sdata1), .q(sdata1_sync));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    shift0_d = shift0_q;
    shift1_d = shift1_q;
    dout0_d  = dout0_q;
    dout1_d  = dout1_q;
`ifdef PMOD_ADC_FRAME_CHECK_EN
    frame_err_d = frame_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start || continuous) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != HALF_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d   = 1'b1;
            shift0_d = {shift0_q[SHIFT_W-2:0], sdata0_sync};
            shift1_d = {shift1_q[SHIFT_W-2:0], sdata1_sync};
          end else if (bit_q == BIT_LAST) begin
            state_d = ST_HOLD;
            dout0_d = shift0_q[DATA_WIDTH-1:0];
            dout1_d = shift1_q[DATA_WIDTH-1:0];
`ifdef PMOD_ADC_FRAME_CHECK_EN
            frame_err_d = (|shift0_q[SHIFT_W-1:DATA_WIDTH]) | (|shift1_q[SHIFT_W-1:DATA_WIDTH]);
`endif
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        state_d = ST_QUIET;
        cnt_d   = '0;
      end
      ST_QUIET: begin
        if (cnt_q != QUIET_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (continuous) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so they line up with state_q.
  always_comb begin
    cs_n_d = !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b1;
      cs_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shift0_q <= '0;
      shift1_q <= '0;
      dout0_q  <= '0;
      dout1_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      shift0_q <= shift0_d;
      shift1_q <= shift1_d;
      dout0_q  <= dout0_d;
      dout1_q  <= dout1_d;
    end
  end

`ifdef PMOD_ADC_FRAME_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`endif

  assign adc_cs_n = cs_n_q;
  assign adc_sclk = sclk_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign dout0    = dout0_q;
  assign dout1    = dout1_q;

endmodule

// File: tb/tb_pmod_adc_reader.sv
// tb/tb_pmod_adc_reader.sv - randomized self-checking bench for pmod_adc_reader with a serial ADC model
module tb_pmod_adc_reader;

  localparam int LAT4  = 1 + 4 + 2 * 4 * 16 + 1;
  localparam int LAT6  = 1 + 6 + 2 * 6 * 16 + 1;
  localparam int QUIET = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic start6 = 1'b0;
  logic cont6 = 1'b0;

  logic busy, done, adc_cs_n, adc_sclk, adc_sdata0, adc_sdata1;
  logic [11:0] dout0, dout1;
  logic busy6, done6, cs_n6, sclk6, sdata0_6, sdata1_6;
  logic [11:0] dout0_6, dout1_6;
`ifdef PMOD_ADC_FRAME_CHECK_EN
  logic frame_err, frame_err6;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pmod_adc_reader dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .busy(busy), .done(done), .dout0(dout0), .dout1(dout1),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .adc_sdata0(adc_sdata0),
`ifdef PMOD_ADC_FRAME_CHECK_EN
    .adc_sdata1(adc_sdata1), .frame_err(frame_err)
`else
    .adc_sdata1(adc_sdata1)
`endif
  );

  pmod_adc_reader #(.CLK_DIV(6)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .continuous(cont6),
    .busy(busy6), .done(done6), .dout0(dout0_6), .dout1(dout1_6),
    .adc_cs_n(cs_n6), .adc_sclk(sclk6),
    .adc_sdata0(sdata0_6),
`ifdef PMOD_ADC_FRAME_CHECK_EN
    .adc_sdata1(sdata1_6), .frame_err(frame_err6)
`else
    .adc_sdata1(sdata1_6)
`endif
  );

  // ADC model: MSB appears when chip select falls, next bit after each SCLK rise.
  logic [15:0] word0 = '0, word1 = '0, word0_6 = '0, word1_6 = '0;
  int rise_cnt = 0, rise_base = 0, rise6_cnt = 0, rise6_base = 0;

  always @(posedge adc_sclk) if (!adc_cs_n) rise_cnt++;
  always @(negedge adc_cs_n) rise_base = rise_cnt;
  always @(posedge sclk6) if (!cs_n6) rise6_cnt++;
  always @(negedge cs_n6) rise6_base = rise6_cnt;

  function automatic logic model_bit(input logic [15:0] w, input int idx);
    return (idx >= 0 && idx < 16) ? w[15-idx] : 1'b0;
  endfunction

  assign adc_sdata0 = model_bit(word0, rise_cnt - rise_base);
  assign adc_sdata1 = model_bit(word1, rise_cnt - rise_base);
  assign sdata0_6   = model_bit(word0_6, rise6_cnt - rise6_base);
  assign sdata1_6   = model_bit(word1_6, rise6_cnt - rise6_base);

  task automatic pulse_start(output int ts);
    @(negedge clk);
    start = 1'b1;
    ts = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (busy === 1'b0) return;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", adc_cs_n); end
    checks++; if (adc_sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b expected 1", adc_sclk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if ({dout0, dout1} !== 24'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", {dout0, dout1}); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || adc_cs_n !== 1'b1) begin errors++; $display("FAIL idle_after_reset: busy %b cs_n %b expected 0/1", busy, adc_cs_n); end
  endtask

  task automatic test_single;
    int ts, td;
    word0 = 16'h0A5C;
    word1 = 16'h0FFF;
    pulse_start(ts);
    wait_done(300, td);
    checks++; if (td - ts !== LAT4) begin errors++; $display("FAIL single_latency: got %0d expected %0d", td - ts, LAT4); end
    checks++; if (dout0 !== 12'hA5C) begin errors++; $display("FAIL single_dout0: got %h expected a5c", dout0); end
    checks++; if (dout1 !== 12'hFFF) begin errors++; $display("FAIL single_dout1: got %h expected fff", dout1); end
    checks++; if (rise_cnt - rise_base !== 16) begin errors++; $display("FAIL single_sclk_edges: got %0d expected 16", rise_cnt - rise_base); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b expected 0", done); end
    repeat (QUIET - 1) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_quiet: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    checks++; if (dout0 !== 12'hA5C) begin errors++; $display("FAIL single_dout_hold: got %h expected a5c", dout0); end
  endtask

  task automatic test_continuous;
    int ts, n, hi_run, min_hi, busy_drop, extra;
    int td[3];
    logic [15:0] e0, e1;
    logic seen_low;
    n = 0; hi_run = 0; min_hi = 1000; busy_drop = 0; seen_low = 1'b0;
    word0 = 16'($urandom); word1 = 16'($urandom);
    e0 = word0; e1 = word1;
    @(negedge clk);
    continuous = 1'b1;
    ts = cyc;
    for (int c = 0; c < 700 && n < 3; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_drop++;
      if (adc_cs_n === 1'b1) hi_run++;
      else begin
        if (seen_low && hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
        seen_low = 1'b1;
        hi_run = 0;
      end
      if (done === 1'b1) begin
        td[n] = cyc;
        checks++; if ({dout0, dout1} !== {e0[11:0], e1[11:0]}) begin errors++; $display("FAIL cont_dout frame %0d: got %h expected %h", n, {dout0, dout1}, {e0[11:0], e1[11:0]}); end
        word0 = 16'($urandom); word1 = 16'($urandom);
        e0 = word0; e1 = word1;
        n++;
        if (n == 3) continuous = 1'b0;
      end
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL cont_frames: got %0d expected 3", n); end
    if (n == 3) begin
      checks++; if (td[0] - ts !== LAT4) begin errors++; $display("FAIL cont_first_latency: got %0d expected %0d", td[0] - ts, LAT4); end
      checks++; if (td[1] - td[0] !== LAT4 + QUIET) begin errors++; $display("FAIL cont_period1: got %0d expected %0d", td[1] - td[0], LAT4 + QUIET); end
      checks++; if (td[2] - td[1] !== LAT4 + QUIET) begin errors++; $display("FAIL cont_period2: got %0d expected %0d", td[2] - td[1], LAT4 + QUIET); end
    end
    checks++; if (busy_drop !== 0) begin errors++; $display("FAIL cont_busy_drop: got %0d low cycles expected 0", busy_drop); end
    checks++; if (min_hi < QUIET) begin errors++; $display("FAIL cont_cs_gap: got %0d expected at least %0d", min_hi, QUIET); end
    extra = 0;
    repeat (300) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++; if (extra !== 0 || busy !== 1'b0) begin errors++; $display("FAIL cont_stop: extra done %0d busy %b expected 0/0", extra, busy); end
  endtask

  task automatic test_start_during_shift;
    int ts, td, extra;
    word0 = 16'($urandom) | 16'h0001;
    word1 = 16'($urandom) | 16'h0001;
    pulse_start(ts);
    for (int p = 0; p < 5; p++) begin
      repeat ($urandom_range(5, 15)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(300, td);
    checks++; if (td - ts !== LAT4) begin errors++; $display("FAIL restart_latency: got %0d expected %0d", td - ts, LAT4); end
    checks++; if (rise_cnt - rise_base !== 16) begin errors++; $display("FAIL restart_sclk_edges: got %0d expected 16", rise_cnt - rise_base); end
    checks++; if (dout0 !== word0[11:0]) begin errors++; $display("FAIL restart_dout0: got %h expected %h", dout0, word0[11:0]); end
    extra = 0;
    repeat (200) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++; if (extra !== 0 || busy !== 1'b0) begin errors++; $display("FAIL restart_no_queue: extra done %0d busy %b expected 0/0", extra, busy); end
  endtask

  task automatic test_reset_mid_frame;
    int ts, td, got_done, found;
    word0 = 16'($urandom);
    word1 = 16'($urandom);
    pulse_start(ts);
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      if (rise_cnt - rise_base == 7 && adc_sclk === 1'b0 && adc_cs_n === 1'b0) found = 1;
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL rst_mid_reach_bit7: got %0d expected 1", found); end
    #2 rst = 1'b1;
    #1;
    checks++; if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b1) begin errors++; $display("FAIL rst_mid_pins: cs_n %b sclk %b expected 1/1", adc_cs_n, adc_sclk); end
    checks++; if ({dout0, dout1} !== 24'h0) begin errors++; $display("FAIL rst_mid_dout: got %h expected 0", {dout0, dout1}); end
    got_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) got_done++;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (got_done !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: done %0d busy %b expected 0/0", got_done, busy); end
    word0 = 16'h0123;
    word1 = 16'($urandom);
    pulse_start(ts);
    wait_done(300, td);
    checks++; if (td - ts !== LAT4) begin errors++; $display("FAIL rst_mid_relatency: got %0d expected %0d", td - ts, LAT4); end
    checks++; if (dout0 !== 12'h123) begin errors++; $display("FAIL rst_mid_dout0: got %h expected 123", dout0); end
    checks++; if (dout1 !== word1[11:0]) begin errors++; $display("FAIL rst_mid_dout1: got %h expected %h", dout1, word1[11:0]); end
    wait_idle(300);
  endtask

  task automatic test_random_frames;
    int ts, td;
    for (int i = 0; i < 4; i++) begin
      word0 = 16'($urandom);
      word1 = 16'($urandom);
      pulse_start(ts);
      wait_done(300, td);
      checks++; if (td - ts !== LAT4) begin errors++; $display("FAIL rand_latency %0d: got %0d expected %0d", i, td - ts, LAT4); end
      checks++; if ({dout0, dout1} !== {word0[11:0], word1[11:0]}) begin errors++; $display("FAIL rand_dout %0d: got %h expected %h", i, {dout0, dout1}, {word0[11:0], word1[11:0]}); end
`ifdef PMOD_ADC_FRAME_CHECK_EN
      checks++; if (frame_err !== ((word0[15:12] != 4'h0) || (word1[15:12] != 4'h0))) begin errors++; $display("FAIL rand_frame_err %0d: got %b", i, frame_err); end
`endif
      wait_idle(300);
    end
  endtask

  task automatic test_clk_div6;
    int ts, td, nlow, bad, run;
    logic cur;
    logic samples[$];
    word0_6 = 16'($urandom);
    word1_6 = 16'($urandom);
    td = -1;
    @(negedge clk);
    start6 = 1'b1;
    ts = cyc;
    @(negedge clk);
    start6 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (cs_n6 === 1'b0) samples.push_back(sclk6);
      if (done6 === 1'b1) begin
        td = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++; if (td - ts !== LAT6) begin errors++; $display("FAIL div6_latency: got %0d expected %0d", td - ts, LAT6); end
    checks++; if ({dout0_6, dout1_6} !== {word0_6[11:0], word1_6[11:0]}) begin errors++; $display("FAIL div6_dout: got %h expected %h", {dout0_6, dout1_6}, {word0_6[11:0], word1_6[11:0]}); end
    // Split the chip-select window into SCLK runs; every run after the setup run must be 6 cycles.
    nlow = 0; bad = 0; run = 0; cur = 1'b1;
    for (int i = 0; i <= samples.size(); i++) begin
      if (i < samples.size() && samples[i] === cur) run++;
      else begin
        if (cur === 1'b0) nlow++;
        if ((cur === 1'b0 || nlow > 0) && run != 6) bad++;
        if (i < samples.size()) begin
          cur = samples[i];
          run = 1;
        end
      end
    end
    checks++; if (nlow !== 16) begin errors++; $display("FAIL div6_low_phases: got %0d expected 16", nlow); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL div6_phase_len: got %0d phases not 6 cycles expected 0", bad); end
  endtask

`ifdef PMOD_ADC_FRAME_CHECK_EN
  task automatic test_frame_check;
    int ts, td;
    word0 = 16'h8123;
    word1 = 16'h0456;
    pulse_start(ts);
    wait_done(300, td);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL fchk_set: got %b expected 1", frame_err); end
    checks++; if (dout0 !== 12'h123) begin errors++; $display("FAIL fchk_dout0: got %h expected 123", dout0); end
    wait_idle(300);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL fchk_hold: got %b expected 1", frame_err); end
    word0 = 16'h0123;
    pulse_start(ts);
    wait_done(300, td);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fchk_clear: got %b expected 0", frame_err); end
    wait_idle(300);
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_continuous;
    test_start_during_shift;
    test_reset_mid_frame;
    test_random_frames;
    test_clk_div6;
`ifdef PMOD_ADC_FRAME_CHECK_EN
    test_frame_check;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1);
  end

endmodule
